// File: rtl/xor_stream_descrambler_if.sv
// Valid/ready word stream; master drives valid/data, slave drives ready.
// Used on both sides of the descrambler, one instance per direction.
interface xor_stream_descrambler_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/xor_stream_descrambler.sv
// XORs each accepted word with a Galois LFSR keystream; 1-cycle latency via one output register.
// in_ready drops while a held word is stalled downstream or during a seed load; 1 word/cycle otherwise.
module xor_stream_descrambler #(
  parameter int                     WIDTH = 16,
  parameter logic [WIDTH-1:0]       SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0]       TAPS  = 16'hB400
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed_in,
  xor_stream_descrambler_if.slave   in_if,
  xor_stream_descrambler_if.master  out_if,
  output logic [WIDTH-1:0]          word_count
);

  logic [WIDTH-1:0] ks_q, ks_d;
  logic [WIDTH-1:0] ks_next;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] word_count_q, word_count_d;
  logic             accept;

  assign in_if.ready = !seed_load && (!out_valid_q || out_if.ready);
  assign accept      = in_if.valid && in_if.ready;
  assign ks_next     = (ks_q >> 1) ^ (ks_q[0] ? TAPS : {WIDTH{1'b0}});

  always_comb begin
    ks_d         = ks_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    word_count_d = word_count_q;

    if (out_valid_q && out_if.ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_data_d   = in_if.data ^ ks_q;
      out_valid_d  = 1'b1;
      ks_d         = ks_next;
      word_count_d = word_count_q + 1'b1;
    end

    // A zero seed would lock the LFSR at zero forever, so substitute SEED.
    if (seed_load) begin
      ks_d         = (seed_in == {WIDTH{1'b0}}) ? SEED : seed_in;
      word_count_d = {WIDTH{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_q         <= SEED;
      out_valid_q  <= 1'b0;
      out_data_q   <= {WIDTH{1'b0}};
      word_count_q <= {WIDTH{1'b0}};
    end else begin
      ks_q         <= ks_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign word_count   = word_count_q;

endmodule

// File: doc/xor_stream_descrambler.md
Name: xor_stream_descrambler

Overview:
- Receive-side counterpart of the ALU's 16-bit bitwise XOR datapath, used as a stream cipher.
- Each accepted ciphertext word is XORed with a 16-bit Galois LFSR keystream word.
- The keystream advances one step per accepted word, recovering the plaintext that a matching scrambler produced.
- Sits between an upstream word source and a downstream consumer. Both sides use valid/ready handshakes, with one registered output stage.

Parameters:
- WIDTH, 16, data and keystream width; only 16 is supported.
- SEED, 16'hACE1, keystream value after reset, and the substitute value when a zero seed is loaded.
- TAPS, 16'hB400, Galois feedback mask for x^16+x^14+x^13+x^11+1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- seed_load  input  1  load seed_in into the keystream register.
- seed_in  input  16  new keystream seed.
- in_valid  input  1  ciphertext word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  16  ciphertext word.
- out_valid  output  1  plaintext word present.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  16  plaintext word.
- word_count  output  16  number of words accepted since reset or the last seed load.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, on rst_n.
- Reset values: ks=SEED, out_valid=0, out_data=0, word_count=0. in_ready=1 once rst_n deasserts.
- in_ready = !seed_load && (!out_valid || out_ready). This is combinational, so back-to-back throughput is 1 word/cycle.
- Accept condition: in_valid && in_ready.
  - On accept: out_data <= in_data ^ ks; out_valid <= 1.
  - On accept: ks <= (ks >> 1) ^ (ks[0] ? TAPS : 0).
  - On accept: word_count <= word_count + 1, wrapping 0xFFFF to 0x0000.
- Latency: a word accepted at edge N is visible on out_data and out_valid after edge N, one cycle.
- Output hold: when out_valid && !out_ready, out_data and out_valid hold, in_ready=0, and ks does not advance.
- Output drain: when out_valid && out_ready and there is no accept, out_valid <= 0 and out_data holds its last value.
- Simultaneous drain and accept: when out_valid && out_ready && accept, the new word replaces the old one and out_valid stays 1.
- Seed load: when seed_load=1, ks <= (seed_in==0) ? SEED : seed_in, and word_count <= 0.
  - No input is accepted that cycle.
  - The output register is unaffected: a pending word stays and may drain that cycle.
- The keystream is never 0 at any time, so the LFSR cannot lock up.
- Reset mid-stream: a pending output word is discarded immediately (out_valid=0 asynchronously), and ks returns to SEED.
- No internal FSM beyond the output-register full/empty state (EMPTY: out_valid=0; FULL: out_valid=1). Transitions are as listed above.

Test Plan:
- Keystream sequence: after reset, hold out_ready=1 and feed 0x0000, 0x0000, 0xFFFF back-to-back. Required out_data: 0xACE1, 0xE270, 0x8EC7 on consecutive cycles; word_count=3.
- Backpressure: hold out_ready=0 and offer 0x0000 twice. The first word is accepted (out_data=0xACE1) and in_ready drops to 0. The second word is held; ks stays 0xE270. Releasing out_ready drains 0xACE1, and the second word then yields 0xE270.
- Seed load: pulse seed_load with seed_in=0x0001, then feed 0x1234 and 0x0000. Required outputs: 0x1235, then 0xB400; in_ready=0 during the seed_load cycle; word_count restarts at 0.
- Zero seed: load seed_in=0x0000, then feed 0x0000. Required output: 0xACE1.
- Reset mid-stream: hold a word in the output register with out_ready=0, then assert rst_n=0 off-edge. out_valid must drop immediately; after release, feeding 0x0000 gives 0xACE1 and word_count=1.
- Round trip: a scrambler model (same SEED, same TAPS) encrypts 100 random words, sent with random in_valid/out_ready stalls. Required: all 100 plaintext words match in order; word_count=100.
